// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encoding, the $0 register id and the default mult/div latency.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         MD_LATENCY_DEF = 32;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit occupancy sequencer: a mult/div accepted in RUN holds busy for MD_LATENCY cycles.
// busy is registered; start is taken only when ready (the pipeline is not stalled) and the FSM is in RUN.
module md_busy_timer
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ready,
   output logic busy
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (start && ready) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_W'(MD_LATENCY - 1);
            end
         end
         MD_BUSY: begin
            // Counter keeps running through unrelated pipeline stalls.
            if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use, branch-operand and HI/LO stalls plus IF flush on taken branch/jump; zero latency.
// Optional HAZ_PERF_CNT_EN adds free-running stall_cycles / flush_count counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_uses_rt,
   input  logic       ID_branch,
   input  logic       ID_branch_taken,
   input  logic       ID_jump,
   input  logic       ID_md_start,
   input  logic       ID_reads_hilo,
   input  logic       EX_MemRead,
   input  logic       EX_RegWrite,
   input  logic [4:0] EX_wreg,
   input  logic       MEM_MemRead,
   input  logic [4:0] MEM_wreg,
   output logic       PCWrite,
   output logic       IDWrite,
   output logic       IF_Flush,
   output logic       ID_EX_Bubble,
   output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   logic ex_hit, mem_hit;
   logic load_use, br_hazard, md_hazard, stall, flush;
   logic busy;

   // rt only counts as an operand when the ID instruction actually reads it.
   assign ex_hit  = (EX_wreg != REG_ZERO) &&
                    ((EX_wreg == ID_rs) || (ID_uses_rt && (EX_wreg == ID_rt)));
   assign mem_hit = (MEM_wreg != REG_ZERO) &&
                    ((MEM_wreg == ID_rs) || (ID_uses_rt && (MEM_wreg == ID_rt)));

   assign load_use  = EX_MemRead && ex_hit;
   assign br_hazard = ID_branch && ((EX_RegWrite && ex_hit) || (MEM_MemRead && mem_hit));
   assign md_hazard = busy && (ID_reads_hilo || ID_md_start);
   assign stall     = load_use || br_hazard || md_hazard;
   assign flush     = !stall && ((ID_branch && ID_branch_taken) || ID_jump);

   md_busy_timer #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_md_busy_timer (
      .clk   (clk),
      .rst   (rst),
      .start (ID_md_start),
      .ready (!stall),
      .busy  (busy)
   );

   always_comb begin
      PCWrite      = 1'b0;
      IDWrite      = 1'b0;
      IF_Flush     = 1'b0;
      ID_EX_Bubble = 1'b0;
      md_busy      = 1'b0;
      if (rst) begin
         PCWrite      = stall;
         IDWrite      = stall;
         ID_EX_Bubble = stall;
         IF_Flush     = flush;
         md_busy      = busy;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q,  flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, PCWrite};
      flush_count_d  = flush_count_q  + {31'd0, IF_Flush};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench with an expectation queue drained by an independent negedge monitor.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_rs, ID_rt, EX_wreg, MEM_wreg;
   logic       ID_uses_rt, ID_branch, ID_branch_taken, ID_jump, ID_md_start, ID_reads_hilo;
   logic       EX_MemRead, EX_RegWrite, MEM_MemRead;
   logic       PCWrite, IDWrite, IF_Flush, ID_EX_Bubble, md_busy;

   // Expected vector order: {PCWrite, IDWrite, IF_Flush, ID_EX_Bubble, md_busy}
   localparam logic [4:0] E_IDLE  = 5'b00000;
   localparam logic [4:0] E_STALL = 5'b11010;
   localparam logic [4:0] E_FLUSH = 5'b00100;
   localparam logic [4:0] E_BSTL  = 5'b11011;
   localparam logic [4:0] E_BUSY  = 5'b00001;

   logic [4:0] exp_q[$];
   string      nm_q[$];
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .ID_rs           (ID_rs),
      .ID_rt           (ID_rt),
      .ID_uses_rt      (ID_uses_rt),
      .ID_branch       (ID_branch),
      .ID_branch_taken (ID_branch_taken),
      .ID_jump         (ID_jump),
      .ID_md_start     (ID_md_start),
      .ID_reads_hilo   (ID_reads_hilo),
      .EX_MemRead      (EX_MemRead),
      .EX_RegWrite     (EX_RegWrite),
      .EX_wreg         (EX_wreg),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_wreg        (MEM_wreg),
      .PCWrite         (PCWrite),
      .IDWrite         (IDWrite),
      .IF_Flush        (IF_Flush),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .md_busy         (md_busy)
   );

   // Monitor: compares the current outputs against the oldest pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [4:0] e, a;
         string      n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         a = {PCWrite, IDWrite, IF_Flush, ID_EX_Bubble, md_busy};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s: got {pc,id,flush,bubble,busy}=%b expected %b", n, a, e);
         end
      end
   end

   task automatic clr();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
      ID_branch = 1'b0; ID_branch_taken = 1'b0; ID_jump = 1'b0;
      ID_md_start = 1'b0; ID_reads_hilo = 1'b0;
      EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_wreg = 5'd0;
      MEM_MemRead = 1'b0; MEM_wreg = 5'd0;
   endtask

   // Inputs are already applied for this cycle; queue the expectation and advance one clock.
   task automatic tick(input string nm, input logic [4:0] e);
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      clr();
      // Reset forces outputs low even with a load-use present on the inputs.
      EX_MemRead = 1'b1; EX_wreg = 5'd2; ID_rs = 5'd2;
      @(posedge clk); #1;
      tick("reset_outputs", E_IDLE);
      rst = 1'b1;

      // lw $2 in EX, add $3,$2,$4 in ID
      clr(); EX_MemRead = 1'b1; EX_wreg = 5'd2; ID_rs = 5'd2; ID_rt = 5'd4; ID_uses_rt = 1'b1;
      tick("load_use_rs", E_STALL);
      clr(); MEM_MemRead = 1'b1; MEM_wreg = 5'd2; ID_rs = 5'd2; ID_rt = 5'd4; ID_uses_rt = 1'b1;
      tick("load_use_release", E_IDLE);

      clr(); EX_MemRead = 1'b1; EX_wreg = 5'd7; ID_rs = 5'd1; ID_rt = 5'd7; ID_uses_rt = 1'b1;
      tick("load_use_rt", E_STALL);
      ID_uses_rt = 1'b0;
      tick("rt_not_used", E_IDLE);

      clr(); EX_MemRead = 1'b1; EX_wreg = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b1;
      tick("reg_zero_no_stall", E_IDLE);

      // beq $5,$6 taken
      clr(); ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_rs = 5'd5; ID_rt = 5'd6; ID_uses_rt = 1'b1;
      tick("beq_taken_flush", E_FLUSH);
      clr();
      tick("after_flush", E_IDLE);

      clr(); ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_rs = 5'd5; ID_rt = 5'd6; ID_uses_rt = 1'b1;
      MEM_MemRead = 1'b1; MEM_wreg = 5'd5;
      tick("beq_mem_load_stall", E_STALL);
      MEM_MemRead = 1'b0; MEM_wreg = 5'd0;
      tick("beq_then_flush", E_FLUSH);

      clr(); ID_branch = 1'b1; ID_rs = 5'd5; ID_rt = 5'd6; ID_uses_rt = 1'b1;
      EX_RegWrite = 1'b1; EX_wreg = 5'd6;
      tick("beq_ex_alu_stall", E_STALL);
      clr(); ID_branch = 1'b1; ID_rs = 5'd5; ID_rt = 5'd6; ID_uses_rt = 1'b1;
      MEM_wreg = 5'd6;
      tick("beq_mem_alu_no_stall", E_IDLE);

      // jump colliding with a load-use
      clr(); ID_jump = 1'b1; ID_rs = 5'd9; EX_MemRead = 1'b1; EX_wreg = 5'd9;
      tick("jump_under_stall", E_STALL);
      EX_MemRead = 1'b0; EX_wreg = 5'd0;
      tick("jump_then_flush", E_FLUSH);

      clr(); ID_jump = 1'b1; ID_branch = 1'b1; ID_rs = 5'd31; EX_RegWrite = 1'b1; EX_wreg = 5'd31;
      tick("jr_operand_stall", E_STALL);

      // mult at t, mfhi from t+1 stalls for MD_LATENCY cycles
      clr(); ID_md_start = 1'b1;
      tick("mult_issue", E_IDLE);
      clr(); ID_reads_hilo = 1'b1;
      for (int i = 1; i <= 32; i++) tick($sformatf("mfhi_stall_t%0d", i), E_BSTL);
      tick("mfhi_proceeds", E_IDLE);

      // back-to-back mult
      clr(); ID_md_start = 1'b1;
      tick("mult_a_issue", E_IDLE);
      for (int i = 1; i <= 32; i++) tick($sformatf("mult_b_stall_t%0d", i), E_BSTL);
      tick("mult_b_issue", E_IDLE);
      clr();
      for (int k = 1; k <= 21; k++) tick($sformatf("busy_k%0d", k), E_BUSY);

      // counter now at 10: async reset with hazards present
      EX_MemRead = 1'b1; EX_wreg = 5'd3; ID_rs = 5'd3; ID_reads_hilo = 1'b1;
      rst = 1'b0;
      tick("reset_mid_busy", E_IDLE);
      #4;
      rst = 1'b1;
      clr(); ID_reads_hilo = 1'b1;
      @(posedge clk); #1;
      tick("mfhi_after_reset", E_IDLE);
      clr(); ID_md_start = 1'b1;
      tick("mult_after_reset", E_IDLE);
      clr();
      tick("busy_after_reissue", E_BUSY);

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: pending=%0d expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
